// File: rtl/free_list_alloc_pkg.sv
// Shared constants and types for the free-list allocator, its sub-blocks and its bench.
package free_list_alloc_pkg;

    localparam int N_NODES = 256;
    localparam int W_PTR   = $clog2(N_NODES);
    localparam int N_REQ   = 2;

    typedef logic [W_PTR-1:0] ptr_t;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

endpackage

// File: rtl/free_list_alloc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts at the requester after the last winner.
module rr_arbiter #(
    parameter int n_req = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [n_req-1:0] i_req,
    input  logic             i_advance,
    output logic [n_req-1:0] o_gnt
);

    localparam int             PW   = (n_req > 1) ? $clog2(n_req) : 1;
    localparam logic [PW-1:0]  LAST = PW'(n_req - 1);

    logic [PW-1:0] r_prio;
    logic [PW-1:0] w_sel;
    int            w_idx;

    // Scan from lowest to highest priority so the highest-priority requester writes last.
    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
        o_gnt = '0;
        w_sel = r_prio;
        w_idx = 0;
        for (int i = n_req - 1; i >= 0; i--) begin
            w_idx = int'(r_prio) + i;
            if (w_idx >= n_req) w_idx = w_idx - n_req;
            if (i_req[w_idx]) begin
                o_gnt        = '0;
                o_gnt[w_idx] = 1'b1;
                w_sel        = PW'(w_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prio <= '0;
        end else if (i_advance) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            r_prio <= (w_sel == LAST) ? '0 : w_sel + 1'b1;
        end
    end

endmodule

// File: rtl/free_list_alloc.sv
// Linked-list free-node allocator: builds the list after reset, then pops/pushes/bypasses nodes.
module free_list_alloc
    import free_list_alloc_pkg::*;
#(
    parameter int n     = N_NODES,
    parameter int w_ptr = $clog2(n),
    parameter int n_req = N_REQ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [n_req-1:0] req,
    input  logic             free_vld,
    input  logic [w_ptr-1:0] free_ptr,
    output logic [n_req-1:0] gnt,
    output logic [w_ptr-1:0] out_ptr,
    output logic             out_ptr_vld,
    output logic [w_ptr:0]   free_cnt,
    output logic             empty,
    output logic             init_done,
    output logic             err
);

    localparam logic [w_ptr-1:0] LAST_IDX = w_ptr'(n - 1);
    localparam logic [w_ptr:0]   FULL_CNT = (w_ptr + 1)'(n);

    state_t           r_state, w_state_nxt;
    logic [w_ptr-1:0] r_init_idx, w_init_nxt;
    logic [w_ptr-1:0] r_head;
    logic [w_ptr-1:0] r_next [n];
    logic [w_ptr:0]   r_free_cnt;
    logic [n_req-1:0] r_gnt, w_arb_gnt;
    logic [w_ptr-1:0] r_out_ptr;
    logic             r_out_vld, r_err;
    logic             w_init_last, w_full;
    logic             w_alloc, w_pop, w_push, w_err;

    assign w_init_last = (r_init_idx == LAST_IDX);
    assign w_init_nxt  = w_init_last ? '0 : r_init_idx + 1'b1;
    assign w_full      = (r_free_cnt == FULL_CNT);

    rr_arbiter #(.n_req(n_req)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (req),
        .i_advance (w_alloc),
        .o_gnt     (w_arb_gnt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_alloc     = 1'b0;
        w_pop       = 1'b0;
        w_push      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_err = free_vld;
                if (w_init_last) w_state_nxt = ST_READY;
            end
            ST_READY: begin
                // A same-cycle free feeds the allocation directly, so an empty list can still grant.
                w_alloc = (|req) && ((r_free_cnt != '0) || free_vld);
                w_pop   = w_alloc && !free_vld;
                w_push  = free_vld && !w_alloc && !w_full;
                w_err   = free_vld && !w_alloc && w_full;
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_INIT;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_init_idx <= '0;
            r_head     <= '0;
            r_free_cnt <= '0;
            r_gnt      <= '0;
            r_out_ptr  <= '0;
            r_out_vld  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_gnt     <= w_alloc ? w_arb_gnt : '0;
            r_out_vld <= w_alloc;
            r_err     <= w_err;
            if (r_state == ST_INIT) begin
                r_init_idx <= w_init_nxt;
                if (w_init_last) begin
                    r_head     <= '0;
                    r_free_cnt <= FULL_CNT;
                end
            end
            if (w_alloc) r_out_ptr <= free_vld ? free_ptr : r_head;
            if (w_pop) begin
                r_head     <= r_next[r_head];
                r_free_cnt <= r_free_cnt - 1'b1;
            end
            if (w_push) begin
                r_head     <= free_ptr;
                r_free_cnt <= r_free_cnt + 1'b1;
            end
        end
    end

    // NOTE: the link array has no reset; INIT rewrites every entry before the list is used.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) r_next[r_init_idx] <= w_init_nxt;
        else if (w_push)        r_next[free_ptr]   <= r_head;
    end

    assign gnt         = r_gnt;
    assign out_ptr     = r_out_ptr;
    assign out_ptr_vld = r_out_vld;
    assign free_cnt    = r_free_cnt;
    assign empty       = (r_free_cnt == '0);
    assign init_done   = (r_state == ST_READY);
    assign err         = r_err;

endmodule

// File: tb/tb_free_list_alloc.sv
// Directed bench for free_list_alloc: expected grants queued by stimulus, checked by a monitor.
module tb_free_list_alloc;
    import free_list_alloc_pkg::*;

    typedef struct packed {
        logic [N_REQ-1:0] gnt;
        ptr_t             ptr;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N_REQ-1:0] req = '0;
    logic             free_vld = 1'b0;
    ptr_t             free_ptr = '0;
    logic [N_REQ-1:0] gnt;
    ptr_t             out_ptr;
    logic             out_ptr_vld;
    logic [W_PTR:0]   free_cnt;
    logic             empty, init_done, err;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    exp_t e_mon;

    free_list_alloc dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .free_vld    (free_vld),
        .free_ptr    (free_ptr),
        .gnt         (gnt),
        .out_ptr     (out_ptr),
        .out_ptr_vld (out_ptr_vld),
        .free_cnt    (free_cnt),
        .empty       (empty),
        .init_done   (init_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic expect_gnt(input logic [N_REQ-1:0] g, input int p);
        exp_t e;
        e.gnt = g;
        e.ptr = ptr_t'(p);
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},       32'(gnt),         0);
        check({tag, "_out_ptr"},   32'(out_ptr),     0);
        check({tag, "_vld"},       32'(out_ptr_vld), 0);
        check({tag, "_free_cnt"},  32'(free_cnt),    0);
        check({tag, "_init_done"}, 32'(init_done),   0);
        check({tag, "_err"},       32'(err),         0);
    endtask

    // Monitor: every presented grant must match the oldest queued expectation.
    always @(negedge clk) begin
        if (out_ptr_vld || (gnt != '0)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_gnt: got gnt=%b out_ptr=%0d vld=%0b expected no grant (t=%0t)",
                         gnt, out_ptr, out_ptr_vld, $time);
            end else begin
                e_mon = exp_q.pop_front();
                check("gnt",     32'(gnt),         32'(e_mon.gnt));
                check("out_ptr", 32'(out_ptr),     32'(e_mon.ptr));
                check("out_vld", 32'(out_ptr_vld), 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (t=%0t)", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        ticks(3);
        check_all_zero("rst");

        // INIT: requests ignored, free pulses err, done after exactly 256 cycles
        rst      = 1'b1;
        free_vld = 1'b1;
        free_ptr = ptr_t'(9);
        req      = 2'b11;
        tick();
        check("init_free_err", 32'(err), 1);
        free_vld = 1'b0;
        tick();
        check("init_err_clear", 32'(err), 0);
        check("init_cnt", 32'(free_cnt), 0);
        ticks(198);
        req = '0;
        ticks(55);
        check("init_done_255", 32'(init_done), 0);
        tick();
        check("init_done_256", 32'(init_done), 1);
        check("full_cnt", 32'(free_cnt), 256);
        check("full_empty", 32'(empty), 0);

        // Free while full is illegal
        free_vld = 1'b1;
        free_ptr = ptr_t'(3);
        tick();
        free_vld = 1'b0;
        check("full_free_err", 32'(err), 1);
        check("full_free_cnt", 32'(free_cnt), 256);
        tick();
        check("full_free_err_clear", 32'(err), 0);

        // Single requester pops 0..3
        req = 2'b01;
        for (int k = 0; k < 4; k++) expect_gnt(2'b01, k);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("pop_cnt", 32'(free_cnt), 32'(256 - k));
        end
        req = '0;
        tick();
        check("idle_vld", 32'(out_ptr_vld), 0);
        check("idle_hold_ptr", 32'(out_ptr), 3);

        // Reset mid-INIT clears everything; rebuild takes a full 256 cycles
        rst = 1'b0;
        #1;
        check_all_zero("rst2");
        tick();
        rst = 1'b1;
        ticks(100);
        rst = 1'b0;
        #1;
        check_all_zero("rst_mid_init");
        tick();
        rst = 1'b1;
        ticks(255);
        check("reinit_done_255", 32'(init_done), 0);
        tick();
        check("reinit_done_256", 32'(init_done), 1);
        check("reinit_cnt", 32'(free_cnt), 256);

        // Two requesters alternate starting from requester 0
        req = 2'b11;
        expect_gnt(2'b01, 0);
        expect_gnt(2'b10, 1);
        expect_gnt(2'b01, 2);
        expect_gnt(2'b10, 3);
        ticks(4);

        // Six more allocations (10 total), then LIFO free of node 5
        req = 2'b01;
        for (int k = 4; k < 10; k++) expect_gnt(2'b01, k);
        ticks(6);
        req = '0;
        check("ten_alloc_cnt", 32'(free_cnt), 246);
        free_vld = 1'b1;
        free_ptr = ptr_t'(5);
        tick();
        free_vld = 1'b0;
        check("push_cnt", 32'(free_cnt), 247);
        check("push_no_err", 32'(err), 0);
        req = 2'b01;
        expect_gnt(2'b01, 5);
        expect_gnt(2'b01, 10);
        ticks(2);
        check("lifo_cnt", 32'(free_cnt), 245);

        // Drain the remaining nodes
        for (int k = 11; k < 256; k++) expect_gnt(2'b01, k);
        ticks(245);
        check("drain_cnt", 32'(free_cnt), 0);
        check("drain_empty", 32'(empty), 1);

        // Empty: held request gets nothing
        ticks(2);
        check("empty_hold_cnt", 32'(free_cnt), 0);
        check("empty_hold_vld", 32'(out_ptr_vld), 0);

        // Empty with same-cycle free: bypass hands the freed node straight out
        free_vld = 1'b1;
        free_ptr = ptr_t'(7);
        expect_gnt(2'b01, 7);
        tick();
        free_vld = 1'b0;
        req      = '0;
        check("bypass_cnt", 32'(free_cnt), 0);
        check("bypass_empty", 32'(empty), 1);
        check("bypass_err", 32'(err), 0);

        // Push into empty list, then requester 1 takes it
        free_vld = 1'b1;
        free_ptr = ptr_t'(7);
        tick();
        free_vld = 1'b0;
        check("push_empty_cnt", 32'(free_cnt), 1);
        check("push_empty_flag", 32'(empty), 0);
        req = 2'b10;
        expect_gnt(2'b10, 7);
        tick();
        req = '0;
        check("last_pop_cnt", 32'(free_cnt), 0);
        tick();
        @(negedge clk);
        check("pending_expect", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
